// File: rtl/judge_frame_ctrl.sv
// judge_frame_ctrl: alternates a MEASURE frame with VOTE_N JUDGE frames,
// latches the validated fruit box as ROI and majority-votes the sort codes.
module judge_frame_ctrl #(
    parameter int H_ACT    = 800,
    parameter int V_ACT    = 600,
    parameter int MIN_W    = 16,
    parameter int MIN_H    = 16,
    parameter int VOTE_N   = 4,
    parameter int VOTE_MIN = 3
) (
    input  logic        pixelclk,
    input  logic        reset,
    input  logic        i_vsync,
    input  logic        start,
    input  logic        stop,
    input  logic        auto_mode,
    input  logic [11:0] meas_hcount_l,
    input  logic [11:0] meas_hcount_r,
    input  logic [11:0] meas_vcount_l,
    input  logic [11:0] meas_vcount_r,
    input  logic [3:0]  i_sort,
    output logic        o_en,
    output logic [11:0] roi_hcount_l,
    output logic [11:0] roi_hcount_r,
    output logic [11:0] roi_vcount_l,
    output logic [11:0] roi_vcount_r,
    output logic [3:0]  o_sort,
    output logic        o_sort_valid,
    output logic        roi_fail,
    output logic        o_busy
);
    typedef enum logic [2:0] {IDLE, MEASURE, LATCH, JUDGE, VOTE} state_t;

    localparam logic [11:0] H_LAST = 12'(H_ACT - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACT - 1);

    state_t      state_q, state_d;
    logic        vsync_q, fe;
    logic        pend_q, pend_d;
    logic        en_q, en_d;
    logic [11:0] hl_q, hl_d, hr_q, hr_d, vl_q, vl_d, vr_q, vr_d;
    logic [3:0]  sort_q, sort_d;
    logic        sort_valid_q, sort_valid_d;
    logic        fail_q, fail_d;
    logic [2:0]  hist_q [16];
    logic [2:0]  hist_d [16];
    logic [2:0]  frm_q, frm_d;
    logic [4:0]  vcnt_q, vcnt_d;
    logic [2:0]  max_q, max_d;
    logic [3:0]  idx_q, idx_d;
    logic [11:0] meas_w, meas_h;
    logic        meas_ok;

    assign fe      = i_vsync & ~vsync_q;
    assign meas_w  = meas_hcount_r - meas_hcount_l + 12'd1;
    assign meas_h  = meas_vcount_r - meas_vcount_l + 12'd1;
    assign meas_ok = (meas_hcount_l < meas_hcount_r) && (meas_w >= 12'(MIN_W)) &&
                     (meas_vcount_l < meas_vcount_r) && (meas_h >= 12'(MIN_H));

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        en_d         = en_q;
        hl_d         = hl_q;
        hr_d         = hr_q;
        vl_d         = vl_q;
        vr_d         = vr_q;
        sort_d       = sort_q;
        sort_valid_d = 1'b0;
        fail_d       = 1'b0;
        hist_d       = hist_q;
        frm_d        = frm_q;
        vcnt_d       = vcnt_q;
        max_d        = max_q;
        idx_d        = idx_q;
        if (stop) begin
            state_d = IDLE;
            en_d    = 1'b0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fe && (pend_q || start)) begin
                        state_d = MEASURE;
                        en_d    = 1'b1;
                        pend_d  = 1'b0;
                    end else if (start) begin
                        pend_d = 1'b1;
                    end
                end
                MEASURE: begin
                    if (fe) begin
                        state_d = LATCH;
                        en_d    = 1'b0;
                    end
                end
                LATCH: begin
                    if (meas_ok) begin
                        hl_d    = meas_hcount_l;
                        hr_d    = meas_hcount_r;
                        vl_d    = meas_vcount_l;
                        vr_d    = meas_vcount_r;
                        hist_d  = '{default: 3'd0};
                        frm_d   = 3'd0;
                        state_d = JUDGE;
                    end else begin
                        // the frame that just started becomes the new measurement frame
                        fail_d  = 1'b1;
                        hl_d    = 12'd0;
                        hr_d    = H_LAST;
                        vl_d    = 12'd0;
                        vr_d    = V_LAST;
                        en_d    = 1'b1;
                        state_d = MEASURE;
                    end
                end
                JUDGE: begin
                    if (fe) begin
                        hist_d[i_sort] = (hist_q[i_sort] == 3'd7) ? 3'd7 : hist_q[i_sort] + 3'd1;
                        frm_d          = frm_q + 3'd1;
                        if (frm_q == 3'(VOTE_N - 1)) begin
                            state_d = VOTE;
                            vcnt_d  = 5'd0;
                            max_d   = 3'd0;
                            idx_d   = 4'd0;
                        end
                    end
                end
                VOTE: begin
                    if (vcnt_q == 5'd16) begin
                        sort_d       = (max_q >= 3'(VOTE_MIN)) ? idx_q : 4'd0;
                        sort_valid_d = 1'b1;
                        en_d         = auto_mode;
                        state_d      = auto_mode ? MEASURE : IDLE;
                    end else begin
                        vcnt_d = vcnt_q + 5'd1;
                        // strict greater-than keeps the lowest index on ties; slot 0 is skipped
                        if (vcnt_q != 5'd0 && hist_q[vcnt_q[3:0]] > max_q) begin
                            max_d = hist_q[vcnt_q[3:0]];
                            idx_d = vcnt_q[3:0];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            pend_q       <= 1'b0;
            en_q         <= 1'b0;
            hl_q         <= 12'd0;
            hr_q         <= H_LAST;
            vl_q         <= 12'd0;
            vr_q         <= V_LAST;
            sort_q       <= 4'd0;
            sort_valid_q <= 1'b0;
            fail_q       <= 1'b0;
            hist_q       <= '{default: 3'd0};
            frm_q        <= 3'd0;
            vcnt_q       <= 5'd0;
            max_q        <= 3'd0;
            idx_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= i_vsync;
            pend_q       <= pend_d;
            en_q         <= en_d;
            hl_q         <= hl_d;
            hr_q         <= hr_d;
            vl_q         <= vl_d;
            vr_q         <= vr_d;
            sort_q       <= sort_d;
            sort_valid_q <= sort_valid_d;
            fail_q       <= fail_d;
            hist_q       <= hist_d;
            frm_q        <= frm_d;
            vcnt_q       <= vcnt_d;
            max_q        <= max_d;
            idx_q        <= idx_d;
        end
    end

    assign o_en         = en_q;
    assign roi_hcount_l = hl_q;
    assign roi_hcount_r = hr_q;
    assign roi_vcount_l = vl_q;
    assign roi_vcount_r = vr_q;
    assign o_sort       = sort_q;
    assign o_sort_valid = sort_valid_q;
    assign roi_fail     = fail_q;
    assign o_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_judge_frame_ctrl.sv
// tb_judge_frame_ctrl: scenario tasks plus randomized measure/judge cycles
// checked against a plain-arithmetic vote and ROI model.
module tb_judge_frame_ctrl;
    localparam int FRAME = 100;
    localparam int VS    = 8;
    localparam logic [47:0] FULL = {12'd0, 12'd799, 12'd0, 12'd599};

    logic        pixelclk = 1'b0;
    logic        reset = 1'b1, i_vsync = 1'b0, start = 1'b0, stop = 1'b0, auto_mode = 1'b0;
    logic [11:0] mhl = '0, mhr = '0, mvl = '0, mvr = '0;
    logic [3:0]  i_sort = '0;

    logic        a_en, a_valid, a_fail, a_busy, b_en, b_valid, b_fail, b_busy;
    logic [11:0] a_hl, a_hr, a_vl, a_vr, b_hl, b_hr, b_vl, b_vr;
    logic [3:0]  a_sort, b_sort;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, valid_a = 0, valid_b = 0, en_a = 0, fail_a = 0, vt_last = 0, vt_prev = 0;
    logic [3:0] exp_a = 4'd0, exp_b = 4'd0;

    judge_frame_ctrl dut_a (
        .pixelclk(pixelclk), .reset(reset), .i_vsync(i_vsync), .start(start), .stop(stop),
        .auto_mode(auto_mode), .meas_hcount_l(mhl), .meas_hcount_r(mhr),
        .meas_vcount_l(mvl), .meas_vcount_r(mvr), .i_sort(i_sort), .o_en(a_en),
        .roi_hcount_l(a_hl), .roi_hcount_r(a_hr), .roi_vcount_l(a_vl), .roi_vcount_r(a_vr),
        .o_sort(a_sort), .o_sort_valid(a_valid), .roi_fail(a_fail), .o_busy(a_busy)
    );

    judge_frame_ctrl #(.VOTE_MIN(2)) dut_b (
        .pixelclk(pixelclk), .reset(reset), .i_vsync(i_vsync), .start(start), .stop(stop),
        .auto_mode(auto_mode), .meas_hcount_l(mhl), .meas_hcount_r(mhr),
        .meas_vcount_l(mvl), .meas_vcount_r(mvr), .i_sort(i_sort), .o_en(b_en),
        .roi_hcount_l(b_hl), .roi_hcount_r(b_hr), .roi_vcount_l(b_vl), .roi_vcount_r(b_vr),
        .o_sort(b_sort), .o_sort_valid(b_valid), .roi_fail(b_fail), .o_busy(b_busy)
    );

    always #5 pixelclk = ~pixelclk;

    always @(negedge pixelclk) begin
        cyc     <= cyc + 1;
        en_a    <= en_a + int'(a_en);
        fail_a  <= fail_a + int'(a_fail);
        valid_b <= valid_b + int'(b_valid);
        if (a_valid) begin
            valid_a <= valid_a + 1;
            vt_prev <= vt_last;
            vt_last <= cyc;
        end
    end

    // Majority: find the highest count among classes 1..15, then the first class holding it.
    function automatic logic [3:0] vote_ref(input logic [3:0] s[4], input int vmin);
        int cnt[16];
        int best;
        for (int c = 0; c < 16; c++) cnt[c] = 0;
        for (int i = 0; i < 4; i++) cnt[s[i]] = (cnt[s[i]] < 7) ? cnt[s[i]] + 1 : 7;
        best = 0;
        for (int c = 1; c < 16; c++) best = (cnt[c] > best) ? cnt[c] : best;
        if (best < vmin || best == 0) return 4'd0;
        for (int c = 1; c < 16; c++) if (cnt[c] == best) return 4'(c);
        return 4'd0;
    endfunction

    function automatic bit roi_ok(input int hl, input int hr, input int vl, input int vr);
        return (hl < hr) && (hr - hl + 1 >= 16) && (vl < vr) && (vr - vl + 1 >= 16);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pixelclk);
            #1;
        end
    endtask

    task automatic frame(input logic [3:0] s);
        i_sort  = s;
        i_vsync = 1'b1;
        tick(VS);
        i_vsync = 1'b0;
        tick(FRAME - VS);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_meas(input int hl, input int hr, input int vl, input int vr);
        mhl = 12'(hl);
        mhr = 12'(hr);
        mvl = 12'(vl);
        mvr = 12'(vr);
    endtask

    task automatic judge_frames(input logic [3:0] s[4]);
        for (int i = 0; i < 4; i++) frame(s[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_chk++;
        if (a_en !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_en_busy: got en=%b busy=%b expected 0/0", a_en, a_busy);
        end
        n_chk++;
        if ({a_hl, a_hr, a_vl, a_vr} !== FULL) begin
            n_fail++;
            $display("FAIL reset_roi: got %0d/%0d/%0d/%0d expected 0/799/0/599", a_hl, a_hr, a_vl, a_vr);
        end
        n_chk++;
        if (a_sort !== 4'd0 || a_valid !== 1'b0 || a_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sort: got sort=%0d valid=%b fail=%b expected 0/0/0", a_sort, a_valid, a_fail);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_judge();
        logic [3:0] s[4];
        int va, ea, fa;
        va = valid_a; ea = en_a; fa = fail_a;
        s = '{4'd5, 4'd5, 4'd3, 4'd5};
        pulse_start();
        frame(4'd0);
        set_meas(100, 300, 50, 250);
        frame(4'd0);
        n_chk++;
        if ({a_hl, a_hr, a_vl, a_vr} !== {12'd100, 12'd300, 12'd50, 12'd250}) begin
            n_fail++;
            $display("FAIL judge_roi: got %0d/%0d/%0d/%0d expected 100/300/50/250", a_hl, a_hr, a_vl, a_vr);
        end
        judge_frames(s);
        exp_a = vote_ref(s, 3);
        exp_b = vote_ref(s, 2);
        n_chk++;
        if (a_sort !== exp_a || valid_a - va !== 1) begin
            n_fail++;
            $display("FAIL judge_sort: got sort=%0d pulses=%0d expected %0d/1", a_sort, valid_a - va, exp_a);
        end
        n_chk++;
        if (en_a - ea !== FRAME || fail_a - fa !== 0) begin
            n_fail++;
            $display("FAIL judge_en: got en_cycles=%0d fails=%0d expected %0d/0", en_a - ea, fail_a - fa, FRAME);
        end
        n_chk++;
        if (a_busy !== 1'b0 || {a_hl, a_hr, a_vl, a_vr} !== {12'd100, 12'd300, 12'd50, 12'd250}) begin
            n_fail++;
            $display("FAIL judge_idle: got busy=%b roi=%0d/%0d expected 0 and roi kept", a_busy, a_hl, a_hr);
        end
    endtask

    task automatic test_roi_fail();
        logic [3:0] s[4];
        int va, ea, fa;
        va = valid_a; ea = en_a; fa = fail_a;
        for (int i = 0; i < 4; i++) s[i] = 4'($urandom_range(1, 3));
        pulse_start();
        frame(4'd0);
        set_meas(200, 210, 50, 250);
        frame(4'd0);
        n_chk++;
        if (fail_a - fa !== 1 || {a_hl, a_hr, a_vl, a_vr} !== FULL) begin
            n_fail++;
            $display("FAIL width_reject: got fails=%0d roi=%0d/%0d/%0d/%0d expected 1 and full frame",
                     fail_a - fa, a_hl, a_hr, a_vl, a_vr);
        end
        n_chk++;
        if (a_en !== 1'b1 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL remeasure_en: got en=%b busy=%b expected 1/1", a_en, a_busy);
        end
        set_meas(300, 315, 100, 114);
        frame(4'd0);
        n_chk++;
        if (fail_a - fa !== 2 || a_en !== 1'b1) begin
            n_fail++;
            $display("FAIL height_reject: got fails=%0d en=%b expected 2/1", fail_a - fa, a_en);
        end
        set_meas(300, 315, 100, 115);
        frame(4'd0);
        n_chk++;
        if ({a_hl, a_hr, a_vl, a_vr} !== {12'd300, 12'd315, 12'd100, 12'd115} || fail_a - fa !== 2) begin
            n_fail++;
            $display("FAIL min_size_accept: got roi=%0d/%0d/%0d/%0d fails=%0d expected 300/315/100/115 and 2",
                     a_hl, a_hr, a_vl, a_vr, fail_a - fa);
        end
        judge_frames(s);
        exp_a = vote_ref(s, 3);
        exp_b = vote_ref(s, 2);
        n_chk++;
        if (a_sort !== exp_a || valid_a - va !== 1 || en_a - ea !== FRAME + 2 * (FRAME - 1)) begin
            n_fail++;
            $display("FAIL fail_then_judge: got sort=%0d pulses=%0d en=%0d expected %0d/1/%0d",
                     a_sort, valid_a - va, en_a - ea, exp_a, FRAME + 2 * (FRAME - 1));
        end
    endtask

    task automatic test_tie();
        logic [3:0] s[4];
        int va, vb;
        va = valid_a; vb = valid_b;
        s = '{4'd2, 4'd2, 4'd7, 4'd7};
        pulse_start();
        frame(4'd0);
        set_meas(100, 300, 50, 250);
        frame(4'd0);
        judge_frames(s);
        exp_a = vote_ref(s, 3);
        exp_b = vote_ref(s, 2);
        n_chk++;
        if (a_sort !== exp_a || valid_a - va !== 1) begin
            n_fail++;
            $display("FAIL tie_below_min: got sort=%0d pulses=%0d expected %0d/1", a_sort, valid_a - va, exp_a);
        end
        n_chk++;
        if (b_sort !== exp_b || valid_b - vb !== 1) begin
            n_fail++;
            $display("FAIL tie_lowest_idx: got sort=%0d pulses=%0d expected %0d/1", b_sort, valid_b - vb, exp_b);
        end
    endtask

    task automatic test_auto();
        logic [3:0] s1[4], s2[4];
        int va;
        va = valid_a;
        s1 = '{4'd9, 4'd9, 4'd4, 4'd9};
        for (int i = 0; i < 4; i++) s2[i] = 4'($urandom_range(0, 3) * 3);
        auto_mode = 1'b1;
        pulse_start();
        frame(4'd0);
        set_meas(10, 500, 20, 400);
        frame(4'd0);
        judge_frames(s1);
        n_chk++;
        if (a_sort !== vote_ref(s1, 3) || valid_a - va !== 1) begin
            n_fail++;
            $display("FAIL auto_first: got sort=%0d pulses=%0d expected %0d/1", a_sort, valid_a - va, vote_ref(s1, 3));
        end
        n_chk++;
        if (a_en !== 1'b1 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_remeasure: got en=%b busy=%b expected 1/1", a_en, a_busy);
        end
        auto_mode = 1'b0;
        frame(4'd0);
        judge_frames(s2);
        exp_a = vote_ref(s2, 3);
        exp_b = vote_ref(s2, 2);
        n_chk++;
        if (a_sort !== exp_a || valid_a - va !== 2 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_second: got sort=%0d pulses=%0d busy=%b expected %0d/2/0",
                     a_sort, valid_a - va, a_busy, exp_a);
        end
        n_chk++;
        if (vt_last - vt_prev !== 5 * FRAME) begin
            n_fail++;
            $display("FAIL auto_spacing: got %0d cycles expected %0d", vt_last - vt_prev, 5 * FRAME);
        end
    endtask

    task automatic test_stop();
        logic [3:0] s[4];
        int va;
        va = valid_a;
        s = '{4'd4, 4'd6, 4'd6, 4'd6};
        pulse_start();
        frame(4'd0);
        set_meas(100, 300, 50, 250);
        frame(4'd0);
        frame(4'd4);
        frame(4'd4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_chk++;
        if (a_busy !== 1'b0 || a_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: got busy=%b en=%b expected 0/0", a_busy, a_en);
        end
        frame(4'd4);
        frame(4'd4);
        frame(4'd4);
        n_chk++;
        if (valid_a - va !== 0 || a_sort !== exp_a || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_hold: got pulses=%0d sort=%0d busy=%b expected 0/%0d/0",
                     valid_a - va, a_sort, a_busy, exp_a);
        end
        pulse_start();
        frame(4'd0);
        frame(4'd0);
        judge_frames(s);
        exp_a = vote_ref(s, 3);
        exp_b = vote_ref(s, 2);
        n_chk++;
        if (a_sort !== exp_a || valid_a - va !== 1) begin
            n_fail++;
            $display("FAIL stop_fresh_hist: got sort=%0d pulses=%0d expected %0d/1", a_sort, valid_a - va, exp_a);
        end
    endtask

    task automatic test_start_stop_reset();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        frame(4'd0);
        n_chk++;
        if (a_busy !== 1'b0 || a_en !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_same: got busy=%b en=%b expected 0/0", a_busy, a_en);
        end
        pulse_start();
        frame(4'd0);
        n_chk++;
        if (a_en !== 1'b1) begin
            n_fail++;
            $display("FAIL measure_entry: got en=%b expected 1", a_en);
        end
        reset = 1'b1;
        tick();
        n_chk++;
        if (a_en !== 1'b0 || a_busy !== 1'b0 || a_sort !== 4'd0 || a_valid !== 1'b0 || a_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got en=%b busy=%b sort=%0d valid=%b fail=%b expected all 0",
                     a_en, a_busy, a_sort, a_valid, a_fail);
        end
        n_chk++;
        if ({a_hl, a_hr, a_vl, a_vr} !== FULL) begin
            n_fail++;
            $display("FAIL mid_reset_roi: got %0d/%0d/%0d/%0d expected 0/799/0/599", a_hl, a_hr, a_vl, a_vr);
        end
        reset = 1'b0;
        exp_a = 4'd0;
        exp_b = 4'd0;
        frame(4'd0);
        n_chk++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clears_pend: got busy=%b expected 0", a_busy);
        end
    endtask

    task automatic test_random();
        logic [3:0] s[4];
        int va, vb, fa, nf, hl, hr, vl, vr;
        for (int it = 0; it < 6; it++) begin
            va = valid_a; vb = valid_b; fa = fail_a; nf = 0;
            pulse_start();
            frame(4'd0);
            for (int k = 0; k < 4; k++) begin
                hl = $urandom_range(0, 700);
                hr = hl + ((k == 3) ? 15 : $urandom_range(11, 23));
                vl = $urandom_range(0, 500);
                vr = vl + ((k == 3) ? 15 : $urandom_range(11, 23));
                set_meas(hl, hr, vl, vr);
                frame(4'd0);
                if (roi_ok(hl, hr, vl, vr)) break;
                nf++;
                n_chk++;
                if ({a_hl, a_hr, a_vl, a_vr} !== FULL || a_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_reject[%0d]: got roi=%0d/%0d en=%b expected full and 1", it, a_hl, a_hr, a_en);
                end
            end
            for (int i = 0; i < 4; i++) s[i] = 4'($urandom_range(0, 3) * 3);
            judge_frames(s);
            exp_a = vote_ref(s, 3);
            exp_b = vote_ref(s, 2);
            n_chk++;
            if ({a_hl, a_hr, a_vl, a_vr} !== {mhl, mhr, mvl, mvr} || fail_a - fa !== nf) begin
                n_fail++;
                $display("FAIL rand_roi[%0d]: got roi=%0d/%0d/%0d/%0d fails=%0d expected %0d/%0d/%0d/%0d and %0d",
                         it, a_hl, a_hr, a_vl, a_vr, fail_a - fa, mhl, mhr, mvl, mvr, nf);
            end
            n_chk++;
            if (a_sort !== exp_a || valid_a - va !== 1 || b_sort !== exp_b || valid_b - vb !== 1) begin
                n_fail++;
                $display("FAIL rand_vote[%0d]: got a=%0d b=%0d pulses=%0d/%0d expected %0d/%0d and 1/1",
                         it, a_sort, b_sort, valid_a - va, valid_b - vb, exp_a, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_judge();
        test_roi_fail();
        test_tie();
        test_auto();
        test_stop();
        test_start_stop_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
